regfile_wb_queue: RTL and testbench

REGFILE_WB_QUEUE -- requirements
Module: regfile_wb_queue

---
 rtl/regfile_wb_queue.sv | 105 ++++++++++
 tb/tb_regfile_wb_queue.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_queue.sv
// Writeback queue between the pipeline and the regfile write port. Holds up to DEPTH
// pending writes in FIFO order and forwards the youngest queued value to the read ports.
module regfile_wb_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic                   clock,
  input  logic                   reset_b,
  input  logic                   in_valid,
  input  logic [AW-1:0]          in_addr,
  input  logic [DW-1:0]          in_data,
  output logic                   in_ready,
  input  logic                   stall,
  output logic                   rf_we,
  output logic [AW-1:0]          rf_wa,
  output logic [DW-1:0]          rf_wd,
  input  logic [AW-1:0]          ra1,
  input  logic [AW-1:0]          ra2,
  input  logic [DW-1:0]          rf_rd1,
  input  logic [DW-1:0]          rf_rd2,
  output logic [DW-1:0]          rd1,
  output logic [DW-1:0]          rd2,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic push;
  logic pop;

  assign in_ready = (count_q < CW'(DEPTH));
  // Writes to register 0 are accepted but never stored.
  assign push     = in_valid && in_ready && (in_addr != '0);
  assign pop      = rf_we;

  assign rf_we = (count_q != '0) && !stall;
  assign rf_wa = (count_q != '0) ? addr_mem[head_q] : '0;
  assign rf_wd = (count_q != '0) ? data_mem[head_q] : '0;
  assign count = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      head_d = head_q + 1'b1;
    end
    if (push) begin
      tail_d = tail_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      addr_mem[tail_q] <= in_addr;
      data_mem[tail_q] <= in_data;
    end
  end

  // Scan oldest to youngest so the last match wins; slots beyond count are ignored.
  always_comb begin
    logic [PW-1:0] idx;
    idx = head_q;
    rd1 = rf_rd1;
    rd2 = rf_rd2;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (CW'(i) < count_q) begin
        if ((ra1 != '0) && (addr_mem[idx] == ra1)) begin
          rd1 = data_mem[idx];
        end
        if ((ra2 != '0) && (addr_mem[idx] == ra2)) begin
          rd2 = data_mem[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: queue-based reference model plus a write scoreboard
// checked by a negedge monitor, driven by directed and random stimulus.
module tb_regfile_wb_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clock = 1'b0;
  logic          reset_b;
  logic          in_valid;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          stall;
  logic          rf_we;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;
  logic [AW-1:0] ra1, ra2;
  logic [DW-1:0] rf_rd1, rf_rd2;
  logic [DW-1:0] rd1, rd2;
  logic [2:0]    count;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t mdl[$];    // current queue contents, oldest first
  ent_t exp_q[$];  // writes still expected on the regfile port

  int n_checks = 0;
  int n_pass   = 0;

  regfile_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clock   (clock),
    .reset_b (reset_b),
    .in_valid(in_valid),
    .in_addr (in_addr),
    .in_data (in_data),
    .in_ready(in_ready),
    .stall   (stall),
    .rf_we   (rf_we),
    .rf_wa   (rf_wa),
    .rf_wd   (rf_wd),
    .ra1     (ra1),
    .ra2     (ra2),
    .rf_rd1  (rf_rd1),
    .rf_rd2  (rf_rd2),
    .rd1     (rd1),
    .rd2     (rd2),
    .count   (count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a write leaves when the queue is non-empty and not stalled;
  // a request enters when there is room and its address is nonzero.
  always @(posedge clock or negedge reset_b) begin : model
    ent_t e;
    bit   do_pop;
    bit   do_acc;
    if (!reset_b) begin
      mdl.delete();
      exp_q.delete();
    end else begin
      do_pop = (mdl.size() != 0) && !stall;
      do_acc = in_valid && (mdl.size() < DEPTH);
      if (do_pop) void'(mdl.pop_front());
      if (do_acc && in_addr != '0) begin
        e.a = in_addr;
        e.d = in_data;
        mdl.push_back(e);
        exp_q.push_back(e);
      end
    end
  end

  always @(negedge clock) begin : monitor
    ent_t          e;
    logic [DW-1:0] e1, e2;
    bit            we;
    we = (mdl.size() != 0) && !stall;
    check("rf_we", rf_we, we);
    check("count", count, mdl.size());
    check("in_ready", in_ready, mdl.size() < DEPTH);
    e1 = rf_rd1;
    e2 = rf_rd2;
    foreach (mdl[i]) begin
      if (ra1 != 0 && mdl[i].a == ra1) e1 = mdl[i].d;
      if (ra2 != 0 && mdl[i].a == ra2) e2 = mdl[i].d;
    end
    check("rd1", rd1, e1);
    check("rd2", rd2, e2);
    if (mdl.size() == 0) begin
      check("rf_wa_empty", rf_wa, 0);
      check("rf_wd_empty", rf_wd, 0);
    end
    if (rf_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("rf_wa", rf_wa, e.a);
        check("rf_wd", rf_wd, e.d);
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    reset_b  = 1'b0;
    in_valid = 1'b0;
    in_addr  = '0;
    in_data  = '0;
    stall    = 1'b0;
    ra1      = '0;
    ra2      = '0;
    rf_rd1   = 32'h1234_5678;
    rf_rd2   = 32'h9ABC_DEF0;
    #2;
    check("reset_count", count, 0);
    check("reset_ready", in_ready, 1);
    check("reset_we", rf_we, 0);
    cyc();
    cyc();
    reset_b = 1'b1;
    cyc();

    // Single write, no stall: visible the cycle after acceptance.
    push(5'd5, 32'h6DC4_50B2);
    check("lat_we", rf_we, 1);
    check("lat_wa", rf_wa, 5);
    check("lat_wd", rf_wd, 32'h6DC4_50B2);
    cyc();
    check("lat_drained", count, 0);

    // Fill under stall, then release.
    stall = 1'b1;
    push(5'd1, 32'h1111_1111);
    push(5'd2, 32'h2222_2222);
    push(5'd3, 32'h3333_3333);
    push(5'd4, 32'h4444_4444);
    check("full_ready", in_ready, 0);
    check("full_count", count, 4);
    check("full_we", rf_we, 0);
    stall = 1'b0;
    repeat (5) cyc();

    // Same-address entries: youngest wins.
    stall = 1'b1;
    push(5'd7, 32'hAAAA_AAAA);
    push(5'd7, 32'hBBBB_BBBB);
    ra1    = 5'd7;
    rf_rd1 = 32'hFBD6_F479;
    ra2    = 5'd8;
    #1;
    check("fwd_young", rd1, 32'hBBBB_BBBB);
    check("fwd_miss", rd2, rf_rd2);
    stall = 1'b0;
    repeat (3) cyc();

    // Register 0 writes are swallowed.
    push(5'd0, 32'hFFFF_FFFF);
    check("zero_count", count, 0);
    ra1 = 5'd0;
    #1;
    check("zero_fwd", rd1, rf_rd1);
    repeat (2) cyc();

    // Asynchronous reset in the middle of a cycle with entries pending.
    stall = 1'b1;
    push(5'd9, 32'h0909_0909);
    push(5'd10, 32'h0A0A_0A0A);
    push(5'd11, 32'h0B0B_0B0B);
    #2;
    reset_b = 1'b0;
    stall   = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_we", rf_we, 0);
    cyc();
    reset_b = 1'b1;
    check("arst_ready", in_ready, 1);
    repeat (4) cyc();

    // Random traffic with toggling stall and random read addresses.
    for (int n = 0; n < 300; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_addr  = AW'($urandom_range(0, 7));
      in_data  = $urandom;
      stall    = ($urandom_range(0, 2) == 0);
      ra1      = AW'($urandom_range(0, 8));
      ra2      = AW'($urandom_range(0, 8));
      rf_rd1   = $urandom;
      rf_rd2   = $urandom;
      cyc();
    end
    in_valid = 1'b0;
    stall    = 1'b0;
    repeat (DEPTH + 3) cyc();
    check("drain_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
